// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared word layout, reset word and scheduler state encoding
//
// Purpose: common definitions for the pixel FIFO write-side scheduler.
//   Word layout: [31] valid, [30] stream_reset, [29:24] zero, [23:16] G,
//   [15:8] R, [7:0] B.
// Ports: none (package).
package rgb_pkg;

  localparam int BNUM_VALID        = 31;
  localparam int BNUM_STREAM_RESET = 30;
  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam logic [31:0] RGB_WORD_RST = 32'hC000_0000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_WRITE    = 3'd2,
    S_DROP     = 3'd3,
    S_RST_PEND = 3'd4
  } sched_state_t;

  // Build a pixel word from a G-R-B triple packed MSB first.
  function automatic logic [31:0] make_pix_word(input logic [23:0] grb);
    logic [31:0] w;
    w = '0;
    w[BNUM_VALID]        = 1'b1;
    w[BNUM_STREAM_RESET] = 1'b0;
    w[G_HI:G_LO]         = grb[23:16];
    w[R_HI:R_LO]         = grb[15:8];
    w[B_HI:B_LO]         = grb[7:0];
    return w;
  endfunction

endpackage

// File: rtl/rgb_fifo_sched_if.sv
// rtl/rgb_fifo_sched_if.sv - FIFO write-side bus between scheduler and pixel FIFO
//
// Purpose: groups the FIFO write handshake.
// Signals:
//   wr_fifo_en    scheduler -> FIFO  1-clock write pulse per word
//   wr_fifo_data  scheduler -> FIFO  32-bit word
//   wr_fifo_full  FIFO -> scheduler  FIFO cannot accept a word this clock
// Modports: master (scheduler side), slave (FIFO side).
interface rgb_fifo_sched_if;
  logic        wr_fifo_en;
  logic [31:0] wr_fifo_data;
  logic        wr_fifo_full;

  modport master (
    output wr_fifo_en,
    output wr_fifo_data,
    input  wr_fifo_full
  );

  modport slave (
    input  wr_fifo_en,
    input  wr_fifo_data,
    output wr_fifo_full
  );
endinterface

// File: rtl/rgb_pix_assemble.sv
// rtl/rgb_pix_assemble.sv - strobe edge detect and 24-bit pixel assembly
//
// Purpose: turns 2-clock decoder strobes into single-clock events and shifts
//   accepted data bits into a G-R-B pixel, MSB first.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_strobe         decoder event strobe (high 2 clocks per event)
//   in_stream_reset   1 = stream-reset event, 0 = data bit
//   in_sbit_value     data bit value
//   bit_en            scheduler accepts bit events this clock
//   evt_bit           single-clock data-bit event (regardless of bit_en)
//   evt_rst           single-clock stream-reset event
//   pix_ready         accepted bit completes a 24-bit pixel this clock
//   pix_grb           completed pixel, valid with pix_ready
module rgb_pix_assemble (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_strobe,
  input  logic        in_stream_reset,
  input  logic        in_sbit_value,
  input  logic        bit_en,
  output logic        evt_bit,
  output logic        evt_rst,
  output logic        pix_ready,
  output logic [23:0] pix_grb
);

  logic        strobe_d;
  logic [22:0] shift_q;   // first 23 bits; the 24th is taken live from the input
  logic [4:0]  bit_cnt;
  logic        strobe_rise;
  logic        take_bit;

  assign strobe_rise = in_strobe & ~strobe_d;
  assign evt_bit     = strobe_rise & ~in_stream_reset;
  assign evt_rst     = strobe_rise & in_stream_reset;
  assign take_bit    = evt_bit & bit_en;
  assign pix_ready   = take_bit & (bit_cnt == 5'd23);
  assign pix_grb     = {shift_q, in_sbit_value};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_d <= 1'b0;
      shift_q  <= '0;
      bit_cnt  <= '0;
    end else begin
      strobe_d <= in_strobe;
      // A stream reset always discards any partial pixel.
      if (evt_rst) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        shift_q <= {shift_q[21:0], in_sbit_value};
        bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/rgb_fifo_sched.sv
// rtl/rgb_fifo_sched.sv - pixel FIFO write-side scheduler (top)
//
// Purpose: packs decoded WS2812b bits into 32-bit FIFO words, caps pixels per
//   frame, handles FIFO-full backpressure and closes every non-empty frame
//   with exactly one stream-reset word.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_strobe         decoder event strobe
//   in_stream_reset   qualifies strobe: 1 = stream reset, 0 = data bit
//   in_sbit_value     data bit value
//   fifo              FIFO write bus (master): wr_fifo_en/data out, wr_fifo_full in
//   out_pixel_count   pixels written in the last completed frame
//   out_frame_done    1-clock pulse with the stream-reset word write
//   out_overflow      sticky: data lost to FIFO full
//   out_truncated     sticky: pixels discarded beyond MAX_PIXELS
module rgb_fifo_sched
  import rgb_pkg::*;
#(
  parameter int MAX_PIXELS = 256,
  localparam int PCW = $clog2(MAX_PIXELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_strobe,
  input  logic                 in_stream_reset,
  input  logic                 in_sbit_value,
  rgb_fifo_sched_if.master     fifo,
  output logic [PCW-1:0]       out_pixel_count,
  output logic                 out_frame_done,
  output logic                 out_overflow,
  output logic                 out_truncated
);

  localparam logic [PCW-1:0] MAX_CNT = PCW'(MAX_PIXELS);

  sched_state_t   state;
  logic [PCW-1:0] frame_pixels;
  logic           last_was_rst;
  logic [31:0]    pix_word_q;
  logic           wr_en_q;
  logic [31:0]    wr_data_q;
  logic           fifo_full;

  logic           bit_en;
  logic           evt_bit;
  logic           evt_rst;
  logic           pix_ready;
  logic [23:0]    pix_grb;

  assign fifo_full         = fifo.wr_fifo_full;
  assign fifo.wr_fifo_en   = wr_en_q;
  assign fifo.wr_fifo_data = wr_data_q;

  // Bits are shifted in while collecting, and also in the clock a pending
  // word leaves, since that bit belongs to the next pixel rather than being lost.
  assign bit_en = (state == S_IDLE) || (state == S_COLLECT) ||
                  (((state == S_WRITE) || (state == S_RST_PEND)) && !fifo_full);

  rgb_pix_assemble u_assemble (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_strobe       (in_strobe),
    .in_stream_reset (in_stream_reset),
    .in_sbit_value   (in_sbit_value),
    .bit_en          (bit_en),
    .evt_bit         (evt_bit),
    .evt_rst         (evt_rst),
    .pix_ready       (pix_ready),
    .pix_grb         (pix_grb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      frame_pixels    <= '0;
      last_was_rst    <= 1'b1;
      pix_word_q      <= '0;
      wr_en_q         <= 1'b0;
      wr_data_q       <= '0;
      out_pixel_count <= '0;
      out_frame_done  <= 1'b0;
      out_overflow    <= 1'b0;
      out_truncated   <= 1'b0;
    end else begin
      wr_en_q        <= 1'b0;
      out_frame_done <= 1'b0;

      case (state)
        S_IDLE, S_COLLECT: begin
          if (evt_rst) begin
            // Back-to-back resets with nothing written in between are absorbed.
            if (last_was_rst && (frame_pixels == '0)) begin
              state <= S_IDLE;
            end else begin
              state <= S_RST_PEND;
            end
          end else if (pix_ready) begin
            if (frame_pixels < MAX_CNT) begin
              pix_word_q <= make_pix_word(pix_grb);
              state      <= S_WRITE;
            end else begin
              out_truncated <= 1'b1;
              state         <= S_COLLECT;
            end
          end else if (evt_bit) begin
            state <= S_COLLECT;
          end
        end

        S_WRITE: begin
          if (!fifo_full) begin
            wr_en_q      <= 1'b1;
            wr_data_q    <= pix_word_q;
            frame_pixels <= (frame_pixels == MAX_CNT) ? frame_pixels
                                                      : frame_pixels + PCW'(1);
            last_was_rst <= 1'b0;
            // A reset arriving in the same clock still closes the frame.
            state        <= evt_rst ? S_RST_PEND : S_COLLECT;
          end else if (evt_bit) begin
            out_overflow <= 1'b1;
            state        <= S_DROP;
          end else if (evt_rst) begin
            out_overflow <= 1'b1;
            state        <= S_RST_PEND;
          end
        end

        S_DROP: begin
          if (evt_rst) begin
            state <= S_RST_PEND;
          end
        end

        S_RST_PEND: begin
          if (!fifo_full) begin
            wr_en_q         <= 1'b1;
            wr_data_q       <= RGB_WORD_RST;
            out_frame_done  <= 1'b1;
            out_pixel_count <= frame_pixels;
            frame_pixels    <= '0;
            last_was_rst    <= 1'b1;
            state           <= evt_bit ? S_COLLECT : S_IDLE;
          end else if (evt_bit) begin
            out_overflow <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fifo_sched.sv
// tb/tb_rgb_fifo_sched.sv - scoreboard testbench for rgb_fifo_sched
module tb_rgb_fifo_sched;

  localparam int TB_MAX = 2;
  localparam int TB_PCW = $clog2(TB_MAX + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_strobe = 1'b0;
  logic in_stream_reset = 1'b0;
  logic in_sbit_value = 1'b0;
  logic [TB_PCW-1:0] out_pixel_count;
  logic out_frame_done;
  logic out_overflow;
  logic out_truncated;

  rgb_fifo_sched_if fifo_if ();

  always #5 clk = ~clk;

  rgb_fifo_sched #(.MAX_PIXELS(TB_MAX)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_strobe       (in_strobe),
    .in_stream_reset (in_stream_reset),
    .in_sbit_value   (in_sbit_value),
    .fifo            (fifo_if),
    .out_pixel_count (out_pixel_count),
    .out_frame_done  (out_frame_done),
    .out_overflow    (out_overflow),
    .out_truncated   (out_truncated)
  );

  typedef struct {
    logic [31:0] data;
    logic        is_rst;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got === req) passed++;
    else $display("FAIL %s got=%h required=%h", name, got, req);
  endtask

  task automatic push_pix(input logic [23:0] grb);
    exp_t e;
    e.data = {8'h80, grb};
    e.is_rst = 1'b0;
    e.cnt = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_rst(input int cnt);
    exp_t e;
    e.data = 32'hC000_0000;
    e.is_rst = 1'b1;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every FIFO write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_if.wr_fifo_en) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_write got=%h required=no_write", fifo_if.wr_fifo_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_data", fifo_if.wr_fifo_data, e.data);
          check("frame_done_with_write", 32'(out_frame_done), 32'(e.is_rst));
          if (e.is_rst) check("pixel_count", 32'(out_pixel_count), e.cnt);
        end
      end else if (out_frame_done) begin
        total++;
        $display("FAIL frame_done_without_write got=1 required=0");
      end
    end
  end

  task automatic strobe(input logic rst_ev, input logic b);
    @(posedge clk); #1;
    in_strobe = 1'b1; in_stream_reset = rst_ev; in_sbit_value = b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_strobe = 1'b0; in_stream_reset = 1'b0; in_sbit_value = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) strobe(1'b0, v[i]);
  endtask

  task automatic send_rst();
    strobe(1'b1, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(fifo_if.wr_fifo_en), 0);
    check({tag, "_wr_data"}, fifo_if.wr_fifo_data, 0);
    check({tag, "_pixel_count"}, 32'(out_pixel_count), 0);
    check({tag, "_frame_done"}, 32'(out_frame_done), 0);
    check({tag, "_overflow"}, 32'(out_overflow), 0);
    check({tag, "_truncated"}, 32'(out_truncated), 0);
  endtask

  initial begin
    fifo_if.wr_fifo_full = 1'b0;

    // 1. reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle_outputs("reset");
    repeat (10) @(posedge clk);
    #1 check("idle_no_write", 32'(fifo_if.wr_fifo_en), 0);

    // 2. one pixel then stream reset
    push_pix(24'h12_34_56);
    push_rst(1);
    send_bits(24'h12_34_56, 24);
    send_rst();
    wait_drain("t2_drain");
    check("t2_pixel_count", 32'(out_pixel_count), 1);

    // 3. backpressure: delayed write, then overflow and drop
    fifo_if.wr_fifo_full = 1'b1;
    push_pix(24'hA1_B2_C3);
    send_bits(24'hA1_B2_C3, 24);
    repeat (40) @(posedge clk);
    #1 check("t3_held_while_full", exp_q.size(), 1);
    fifo_if.wr_fifo_full = 1'b0;
    wait_drain("t3_delayed_drain");
    check("t3_overflow_clear", 32'(out_overflow), 0);
    fifo_if.wr_fifo_full = 1'b1;
    send_bits(24'hD4_E5_F6, 24);
    send_bits(24'h00000B, 4);
    #1 check("t3_overflow_set", 32'(out_overflow), 1);
    push_rst(1);
    send_rst();
    repeat (20) @(posedge clk);
    #1 check("t3_rst_held", exp_q.size(), 1);
    fifo_if.wr_fifo_full = 1'b0;
    wait_drain("t3_rst_drain");

    // 4. pixel cap (MAX_PIXELS=2)
    push_pix(24'h01_02_03);
    push_pix(24'h04_05_06);
    push_rst(2);
    send_bits(24'h01_02_03, 24);
    send_bits(24'h04_05_06, 24);
    send_bits(24'h07_08_09, 24);
    send_rst();
    wait_drain("t4_drain");
    check("t4_truncated", 32'(out_truncated), 1);
    check("t4_pixel_count", 32'(out_pixel_count), 2);

    // 5. partial pixel discarded, frame still closed once
    push_pix(24'h11_11_11);
    send_bits(24'h11_11_11, 24);
    wait_drain("t5_pix_drain");
    push_rst(1);
    send_bits(24'h0002AA, 10);
    send_rst();
    wait_drain("t5_rst_drain");
    send_rst();
    repeat (20) @(posedge clk);
    #1 check("t5_second_rst_no_write", exp_q.size(), 0);

    // 6. reset mid-pixel
    send_bits(24'h000ABC, 12);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle_outputs("midreset");
    push_pix(24'hAA_BB_CC);
    send_bits(24'hAA_BB_CC, 24);
    wait_drain("t6_pix_drain");
    push_rst(1);
    send_rst();
    wait_drain("t6_rst_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
